// File: rtl/ped_pkg.sv
// Shared definitions for the ped64 output merge: field width, record tags,
// FSM encoding and the output record layout.
package ped_pkg;
  localparam int FIELD_SIZE = 253;
  localparam int CNT_W      = 8;

  localparam logic TAG_LEAF = 1'b0;
  localparam logic TAG_RES  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEAF = 2'd1,
    ST_RES  = 2'd2
  } state_t;

  typedef struct packed {
    logic                  tag;
    logic                  eop;
    logic [CNT_W-1:0]      cnt;
    logic [FIELD_SIZE-1:0] data;
  } rec_t;
endpackage

// File: rtl/ped_sync_fifo.sv
// Flop-based synchronous FIFO; head is presented from the storage array so a
// pop and the consumer's register load happen on the same edge.
module ped_sync_fifo #(
  parameter int WIDTH = 254,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign o_full  = (count == FULL_CNT);
  assign o_empty = (count == '0);
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;
  assign o_dout  = mem[rd_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= i_din;
  end
endmodule

// File: rtl/ped_out_merge.sv
// Merges the ped64 leaf and result streams into one framed record stream:
// every leaf of a job in order, then the job's result tagged end-of-packet.
module ped_out_merge
  import ped_pkg::*;
#(
  parameter int FIELD_SIZE = ped_pkg::FIELD_SIZE,
  parameter int LVS_DEPTH  = 8,
  parameter int MAX_LVS    = 64,
  parameter int CNT_W      = ped_pkg::CNT_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_lvs_vld,
  input  logic [FIELD_SIZE-1:0] i_lvs,
  input  logic                  i_lvs_last,
  output logic                  o_lvs_rdy,
  input  logic                  i_res_vld,
  input  logic [FIELD_SIZE-1:0] i_res,
  output logic                  o_res_rdy,
  output logic                  o_vld,
  output logic [FIELD_SIZE-1:0] o_data,
  output logic                  o_tag,
  output logic [CNT_W-1:0]      o_cnt,
  output logic                  o_eop,
  input  logic                  i_rdy,
  output logic                  o_busy,
  output logic                  o_err
);
  localparam int FIFO_W = FIELD_SIZE + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                state_q;
  state_t                state_d;
  logic                  lvs_en_q;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic [FIFO_W-1:0]     head;
  logic                  head_last;
  logic [FIELD_SIZE-1:0] head_data;
  logic                  load_ok;
  logic                  ld_leaf;
  logic                  ld_res;
  logic                  res_rdy;
  logic [CNT_W-1:0]      leaf_idx;
  logic [CNT_W-1:0]      lvs_cnt_q;
  logic                  err_q;
  logic                  vld_p1;
  rec_t                  rec_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Leaf input stage: buffer {last, data} so ped64 runs ahead of the consumer
  assign o_lvs_rdy = lvs_en_q && !fifo_full;
  assign fifo_push = i_lvs_vld && o_lvs_rdy;
  assign {head_last, head_data} = head;

  ped_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (LVS_DEPTH)
  ) u_lvs_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (fifo_push),
    .i_din   ({i_lvs_last, i_lvs}),
    .i_pop   (ld_leaf),
    .o_dout  (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign load_ok = !vld_p1 || i_rdy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_LEAF: begin
        if (ld_leaf) state_d = head_last ? ST_RES : ST_LEAF;
      end
      ST_RES: begin
        if (ld_res) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ld_leaf  = 1'b0;
    res_rdy  = 1'b0;
    leaf_idx = lvs_cnt_q;
    case (state_q)
      ST_IDLE: begin
        ld_leaf  = !fifo_empty && load_ok;
        leaf_idx = '0;
      end
      ST_LEAF: ld_leaf = !fifo_empty && load_ok;
      ST_RES:  res_rdy = load_ok;
      default: ;
    endcase
  end

  assign ld_res    = res_rdy && i_res_vld;
  assign o_res_rdy = res_rdy;
  assign o_busy    = (state_q != ST_IDLE) || !fifo_empty;

  // Output record stage: unload and reload may share one edge
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lvs_en_q  <= 1'b0;
      vld_p1    <= 1'b0;
      rec_p1    <= '0;
      lvs_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      lvs_en_q <= 1'b1;
      if (ld_leaf) begin
        vld_p1    <= 1'b1;
        rec_p1    <= '{tag: TAG_LEAF, eop: 1'b0, cnt: leaf_idx, data: head_data};
        lvs_cnt_q <= sat_inc(leaf_idx);
        if (int'(leaf_idx) >= MAX_LVS) err_q <= 1'b1;
      end else if (ld_res) begin
        vld_p1 <= 1'b1;
        rec_p1 <= '{tag: TAG_RES, eop: 1'b1, cnt: lvs_cnt_q, data: i_res};
      end else if (i_rdy) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign o_vld  = vld_p1;
  assign o_data = rec_p1.data;
  assign o_tag  = rec_p1.tag;
  assign o_cnt  = rec_p1.cnt;
  assign o_eop  = rec_p1.eop;
  assign o_err  = err_q;
endmodule

// File: tb/tb_ped_out_merge.sv
// Bench for ped_out_merge: cycle table, directed corner sequences and a
// randomized run against a job-level reference model.
module tb_ped_out_merge;
  localparam int FS    = 253;
  localparam int DEPTH = 8;
  localparam int MAXL  = 64;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_lvs_vld = 1'b0;
  logic [FS-1:0] i_lvs = '0;
  logic          i_lvs_last = 1'b0;
  logic          o_lvs_rdy;
  logic          i_res_vld = 1'b0;
  logic [FS-1:0] i_res = '0;
  logic          o_res_rdy;
  logic          o_vld;
  logic [FS-1:0] o_data;
  logic          o_tag;
  logic [CW-1:0] o_cnt;
  logic          o_eop;
  logic          i_rdy = 1'b1;
  logic          o_busy;
  logic          o_err;

  ped_out_merge #(
    .FIELD_SIZE (FS),
    .LVS_DEPTH  (DEPTH),
    .MAX_LVS    (MAXL),
    .CNT_W      (CW)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_lvs_vld  (i_lvs_vld),
    .i_lvs      (i_lvs),
    .i_lvs_last (i_lvs_last),
    .o_lvs_rdy  (o_lvs_rdy),
    .i_res_vld  (i_res_vld),
    .i_res      (i_res),
    .o_res_rdy  (o_res_rdy),
    .o_vld      (o_vld),
    .o_data     (o_data),
    .o_tag      (o_tag),
    .o_cnt      (o_cnt),
    .o_eop      (o_eop),
    .i_rdy      (i_rdy),
    .o_busy     (o_busy),
    .o_err      (o_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [271:0] got, input logic [271:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [FS-1:0] rnd_field();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r[FS-1:0];
  endfunction

  // Reference model: leaves in acceptance order, results in acceptance order;
  // each job's result follows its last leaf and carries the job's leaf count.
  typedef struct {
    logic [FS-1:0] data;
    int            cnt;
    int            tot;
    logic          last;
  } lf_t;

  lf_t           lq[$];
  logic [FS-1:0] rq[$];
  int            lv_idx = 0;
  bit            await_res = 0;
  int            res_total = 0;
  bit            exp_err = 0;
  int            n_eop = 0;
  int            last_res_cnt = 0;
  bit            have_hold = 0;
  logic [263:0]  hold_rec;

  initial begin
    lf_t e;
    logic [FS-1:0] rd;
    forever begin
      @(negedge clk);
      if (rst) begin
        lq.delete();
        rq.delete();
        lv_idx = 0;
        await_res = 0;
        exp_err = 0;
        have_hold = 0;
      end else begin
        if (have_hold) chk("hold_stable", {o_vld, o_tag, o_eop, o_cnt, o_data}, hold_rec);
        have_hold = o_vld && !i_rdy;
        hold_rec = {o_vld, o_tag, o_eop, o_cnt, o_data};
        if (o_vld && !o_tag && int'(o_cnt) >= MAXL) exp_err = 1;
        if (o_vld && i_rdy) begin
          chk("err_flag", o_err, exp_err);
          if (o_eop) n_eop++;
          if (!await_res) begin
            if (lq.size() == 0) chk("leaf_unexpected", o_vld, 1'b0);
            else begin
              e = lq.pop_front();
              chk("leaf_rec", {o_tag, o_eop, o_cnt, o_data}, {1'b0, 1'b0, 8'(e.cnt), e.data});
              if (e.last) begin
                await_res = 1;
                res_total = e.tot;
              end
            end
          end else begin
            if (rq.size() == 0) chk("res_unexpected", o_vld, 1'b0);
            else begin
              rd = rq.pop_front();
              last_res_cnt = int'(o_cnt);
              chk("res_rec", {o_tag, o_eop, o_cnt, o_data}, {1'b1, 1'b1, 8'(res_total), rd});
              await_res = 0;
            end
          end
        end
        if (i_lvs_vld && o_lvs_rdy) begin
          e.data = i_lvs;
          e.cnt  = (lv_idx > 255) ? 255 : lv_idx;
          e.tot  = (lv_idx + 1 > 255) ? 255 : lv_idx + 1;
          e.last = i_lvs_last;
          lq.push_back(e);
          lv_idx = i_lvs_last ? 0 : lv_idx + 1;
        end
        if (i_res_vld && o_res_rdy) rq.push_back(i_res);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_leaf(input logic [FS-1:0] d, input logic last);
    int t;
    t = 0;
    i_lvs = d; i_lvs_last = last; i_lvs_vld = 1'b1;
    @(negedge clk);
    while (!o_lvs_rdy && t < 3000) begin t++; @(negedge clk); end
    if (!o_lvs_rdy) chk("leaf_accept_timeout", o_lvs_rdy, 1'b1);
    @(posedge clk); #1;
    i_lvs_vld = 1'b0;
  endtask

  task automatic send_res(input logic [FS-1:0] d);
    int t;
    t = 0;
    i_res = d; i_res_vld = 1'b1;
    @(negedge clk);
    while (!o_res_rdy && t < 3000) begin t++; @(negedge clk); end
    if (!o_res_rdy) chk("res_accept_timeout", o_res_rdy, 1'b1);
    @(posedge clk); #1;
    i_res_vld = 1'b0;
  endtask

  task automatic wait_eops(input string nm, input int tgt);
    int t;
    t = 0;
    while (n_eop < tgt && t < 5000) begin t++; @(negedge clk); end
    chk(nm, n_eop, tgt);
    idle(3);
  endtask

  typedef struct {
    int lv, ld, ll, rv, rd, rdy;
    int ev, ed, et, ec, ee, elr, eres, eb;
  } vec_t;
  vec_t vecs[7];

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, o_vld=%0b o_busy=%0b", o_vld, o_busy);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, k, base, t_last, t_res, n;
    bit took;
    //         lv  ld    ll rv rd    rdy ev ed    et ec ee elr eres eb
    vecs[0] = '{1, 'h11, 0, 0, 'h00, 1,  0, 'h00, 0, 0, 0, 1,  0,   0};
    vecs[1] = '{1, 'h22, 0, 0, 'h00, 1,  0, 'h00, 0, 0, 0, 1,  0,   1};
    vecs[2] = '{1, 'h33, 1, 0, 'h00, 1,  1, 'h11, 0, 0, 0, 1,  0,   1};
    vecs[3] = '{0, 'h00, 0, 1, 'hAB, 1,  1, 'h22, 0, 1, 0, 1,  0,   1};
    vecs[4] = '{0, 'h00, 0, 1, 'hAB, 1,  1, 'h33, 0, 2, 0, 1,  1,   1};
    vecs[5] = '{0, 'h00, 0, 0, 'h00, 1,  1, 'hAB, 1, 3, 1, 1,  0,   0};
    vecs[6] = '{0, 'h00, 0, 0, 'h00, 1,  0, 'h00, 0, 0, 0, 1,  0,   0};

    // reset state
    #3;
    chk("reset_outs", {o_vld, o_data, o_tag, o_cnt, o_eop, o_err, o_busy, o_res_rdy, o_lvs_rdy}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("lvs_rdy_at_release", o_lvs_rdy, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lvs_rdy_after_release", o_lvs_rdy, 1'b1);
    @(posedge clk); #1;

    // test 1: single job, cycle table
    for (int i = 0; i < 7; i++) begin
      i_lvs_vld = 1'(vecs[i].lv); i_lvs = FS'(vecs[i].ld); i_lvs_last = 1'(vecs[i].ll);
      i_res_vld = 1'(vecs[i].rv); i_res = FS'(vecs[i].rd); i_rdy = 1'(vecs[i].rdy);
      @(negedge clk);
      chk($sformatf("t1_v%0d_ctl", i), {o_vld, o_lvs_rdy, o_res_rdy, o_busy},
          {1'(vecs[i].ev), 1'(vecs[i].elr), 1'(vecs[i].eres), 1'(vecs[i].eb)});
      if (vecs[i].ev != 0)
        chk($sformatf("t1_v%0d_rec", i), {o_tag, o_eop, o_cnt, o_data},
            {1'(vecs[i].et), 1'(vecs[i].ee), 8'(vecs[i].ec), FS'(vecs[i].ed)});
      @(posedge clk); #1;
    end
    i_lvs_vld = 1'b0; i_res_vld = 1'b0;

    // test 2: result offered before any leaf
    base = n_eop;
    fork
      begin send_res(FS'('hE2)); t_res = cyc; end
      begin
        repeat (4) begin @(negedge clk); chk("early_res_rdy", o_res_rdy, 1'b0); end
        @(posedge clk); #1;
        send_leaf(FS'('hE0), 1'b0);
        send_leaf(FS'('hE1), 1'b1);
        t_last = cyc;
      end
    join
    chk("early_res_latency", t_res - t_last, 2);
    wait_eops("t2_drain", base + 1);

    // test 3: backpressure with 10 leaves offered
    base = n_eop;
    i_rdy = 1'b0; acc = 0; k = 0;
    i_lvs = FS'('h200); i_lvs_last = 1'b0; i_lvs_vld = 1'b1;
    repeat (20) begin
      @(negedge clk);
      took = i_lvs_vld && o_lvs_rdy;
      if (took) acc++;
      @(posedge clk); #1;
      if (took) begin
        k++;
        i_lvs = FS'('h200 + k); i_lvs_last = (k == 9); i_lvs_vld = (k < 10);
      end
    end
    chk("bp_accepted", acc, DEPTH + 1);
    @(negedge clk);
    chk("bp_lvs_rdy", o_lvs_rdy, 1'b0);
    chk("bp_head", {o_vld, o_tag, o_cnt, o_data}, {1'b1, 1'b0, 8'd0, FS'('h200)});
    @(posedge clk); #1;
    i_rdy = 1'b1;
    while (k < 10) begin send_leaf(FS'('h200 + k), k == 9); k++; end
    send_res(FS'('hBEEF));
    wait_eops("t3_drain", base + 1);

    // test 4: randomized traffic, 100 jobs
    base = n_eop;
    fork
      begin
        fork
          for (int j = 0; j < 100; j++) begin
            n = $urandom_range(8, 1);
            for (int q = 0; q < n; q++) begin
              if ($urandom_range(1, 0) == 1) idle(1);
              send_leaf(rnd_field(), q == n - 1);
            end
          end
          for (int j = 0; j < 100; j++) begin
            if ($urandom_range(1, 0) == 1) idle(1);
            send_res(rnd_field());
          end
        join
        took = 1;
      end
      begin
        took = 0;
        while (!took) begin @(posedge clk); #1; i_rdy = 1'($urandom_range(1, 0)); end
      end
    join
    i_rdy = 1'b1;
    wait_eops("t4_eop_count", base + 100);
    chk("t4_err", o_err, 1'b0);

    // test 5: 66-leaf job overflows MAX_LVS
    base = n_eop;
    fork
      for (int q = 0; q < 66; q++) send_leaf(FS'('h5000 + q), q == 65);
      send_res(FS'('h5AA));
    join
    wait_eops("t5_drain", base + 1);
    chk("t5_res_cnt", last_res_cnt, 66);
    chk("t5_err_sticky", o_err, 1'b1);

    // test 6: async reset mid-job
    send_leaf(FS'('h51), 1'b0);
    send_leaf(FS'('h52), 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_outs", {o_vld, o_data, o_tag, o_cnt, o_eop, o_err, o_busy, o_res_rdy, o_lvs_rdy}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_fifo_empty", o_busy, 1'b0);
    @(posedge clk); #1;
    base = n_eop;
    send_leaf(FS'('h61), 1'b0);
    send_leaf(FS'('h62), 1'b1);
    @(negedge clk);
    chk("t6_first_after_rst", {o_vld, o_tag, o_cnt, o_data}, {1'b1, 1'b0, 8'd0, FS'('h61)});
    @(posedge clk); #1;
    send_res(FS'('h6F));
    wait_eops("t6_drain", base + 1);
    chk("t6_res_cnt", last_res_cnt, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
